// File: rtl/uart_sample_rx.sv
// 8N1 UART receiver that reassembles BYTES_PER_WORD bytes (MSB byte first) into one
// sample word; used to capture and self-check the decimated-sample serial link.
module uart_sample_rx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int BYTES_PER_WORD = 3,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [7:0]                  byte_out,
  output logic                        byte_valid,
  output logic [8*BYTES_PER_WORD-1:0] sample_out,
  output logic                        sample_valid,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int CW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT) + 1;
  localparam int WW = 8 * BYTES_PER_WORD;
  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_d;
  logic          rx_m, rx_s;
  logic [CW-1:0] clk_cnt, clk_cnt_d;
  logic [CW-1:0] idle_cnt;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg;
  logic [IW-1:0] byte_idx;
  logic [WW-1:0] word_sh;
  logic [WW-1:0] word_next;
  logic          take_bit, stop_ok, stop_bad, timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_d;
      clk_cnt <= clk_cnt_d;
      bit_idx <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt + 1'b1;
    bit_idx_d = bit_idx;
    take_bit  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_d = '0;
          take_bit  = 1'b1;
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // a held-low break must not be mistaken for a new start bit
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign timeout   = (state == IDLE) && (byte_idx != '0) && (idle_cnt == TO_LAST);
  assign word_next = WW'({word_sh, shreg});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg        <= '0;
      byte_out     <= '0;
      byte_valid   <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      byte_idx     <= '0;
      word_sh      <= '0;
      idle_cnt     <= '0;
    end else begin
      byte_valid   <= stop_ok;
      frame_err    <= stop_bad;
      sample_valid <= 1'b0;
      if (take_bit) shreg <= {rx_s, shreg[7:1]};

      if (stop_ok) begin
        byte_out <= shreg;
        if (byte_idx == IDX_LAST) begin
          sample_out   <= word_next;
          sample_valid <= 1'b1;
          byte_idx     <= '0;
          word_sh      <= '0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
          word_sh  <= word_next;
        end
      end else if (stop_bad || timeout) begin
        byte_idx <= '0;
        word_sh  <= '0;
      end

      if ((state == IDLE) && (byte_idx != '0) && !timeout) idle_cnt <= idle_cnt + 1'b1;
      else idle_cnt <= '0;
    end
  end

endmodule
